// File: rtl/tx_inband_pkg.sv
// tx_inband_pkg: shared constants and state encoding for the transmit in-band path
package tx_inband_pkg;
    typedef enum logic [1:0] {IDLE, BURST, RELEASE} arb_state_t;
    localparam int PKT_BYTES = 512;
    localparam int PKT_WORDS_DEFAULT = PKT_BYTES / 4;
    function automatic int cmd_index(input int num_chan);
        return num_chan;
    endfunction
    function automatic int oh2idx(input logic [15:0] oh);
        int idx = 0;
        for (int i = 0; i < 16; i++) if (oh[i]) idx = i;
        return idx;
    endfunction
endpackage

// File: rtl/tx_ram_arbiter_if.sv
// tx_ram_arbiter_if: requester-side and RAM-side signals of the transmit RAM arbiter
interface tx_ram_arbiter_if #(parameter int NUM_CHAN = 2);
    logic [NUM_CHAN:0] req, rd, done, grant, overrun, timeout;
    logic [31:0] ram_data, data;
    logic clear_status, ram_rd, ram_rd_done, busy;
    logic [7:0] word_count;
    modport master (
        output req, rd, done, ram_data, clear_status,
        input ram_rd, ram_rd_done, data, grant, busy, word_count, overrun, timeout
    );
    modport slave (
        input req, rd, done, ram_data, clear_status,
        output ram_rd, ram_rd_done, data, grant, busy, word_count, overrun, timeout
    );
endinterface

// File: rtl/tx_ram_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, one-hot winner is the first masked requester after last
module rr_pick #(
    parameter int N = 3,
    parameter int LW = $clog2(N)
) (
    input logic [N-1:0] req,
    input logic [LW-1:0] last,
    input logic [N-1:0] mask,
    output logic [N-1:0] win
);
    logic [LW:0] sft;
    logic [N-1:0] s, p;
    assign sft = {1'b0, last} + (LW + 1)'(1);
    // rotate so bit 0 is the index after last, isolate lowest set bit, rotate back
    assign s = N'({req & mask, req & mask} >> sft);
    assign p = s & (-s);
    assign win = N'(({p, p} << sft) >> N);
endmodule

// File: rtl/tx_ram_arbiter.sv
// tx_ram_arbiter: shares the transmit packet RAM read port among data channels and the command reader,
// holding each grant for a whole packet and policing length and stalls with sticky flags.
module tx_ram_arbiter
    import tx_inband_pkg::*;
#(
    parameter int NUM_CHAN = 2,
    parameter int PKT_WORDS = PKT_WORDS_DEFAULT,
    parameter int TIMEOUT = 255,
    parameter int CMD_PRIORITY = 1
) (
    input logic txclk,
    input logic reset,
    tx_ram_arbiter_if.slave bus
);
    localparam int W = NUM_CHAN + 1;
    localparam int LW = $clog2(W);
    localparam logic [W-1:0] CMD_OH = W'(1) << cmd_index(NUM_CHAN);
    arb_state_t state, state_nxt;
    logic [W-1:0] grant_q, pick, win, mask, overrun_q, timeout_q;
    logic [LW-1:0] last;
    logic [7:0] wc, idle_cnt;
    logic own_rd, own_done, fwd, ovr_set, to_set, cmd_owner;

    assign mask = CMD_PRIORITY != 0 ? ~CMD_OH : '1;
    rr_pick #(.N(W)) u_pick (.req(bus.req), .last(last), .mask(mask), .win(pick));
    assign win = (CMD_PRIORITY != 0 && bus.req[NUM_CHAN]) ? CMD_OH : pick;
    assign own_rd = |(bus.rd & grant_q);
    assign own_done = |(bus.done & grant_q);
    assign cmd_owner = CMD_PRIORITY != 0 && grant_q[NUM_CHAN];

    always_ff @(posedge txclk)
        state <= reset ? IDLE : state_nxt;

    always_comb begin
        fwd = state == BURST && own_rd && wc < 8'(PKT_WORDS);
        ovr_set = state == BURST && own_rd && wc == 8'(PKT_WORDS);
        to_set = state == BURST && !own_rd && !own_done && idle_cnt == 8'(TIMEOUT - 1);
        state_nxt = state == IDLE ? (|bus.req ? BURST : IDLE)
                  : state == BURST ? ((own_done || to_set) ? RELEASE : BURST)
                  : IDLE;
    end

    always_ff @(posedge txclk) begin
        if (reset) begin
            grant_q <= '0;
            wc <= '0;
            idle_cnt <= '0;
            last <= LW'(NUM_CHAN);
            overrun_q <= '0;
            timeout_q <= '0;
        end else begin
            overrun_q <= (bus.clear_status ? '0 : overrun_q) | (ovr_set ? grant_q : '0);
            timeout_q <= (bus.clear_status ? '0 : timeout_q) | (to_set ? grant_q : '0);
            if (state == IDLE && |bus.req) begin
                grant_q <= win;
                wc <= '0;
                idle_cnt <= '0;
            end
            if (state == BURST) begin
                wc <= wc + 8'(fwd);
                idle_cnt <= own_rd ? '0 : own_done ? idle_cnt : idle_cnt + 8'd1;
                if (state_nxt == RELEASE) begin
                    grant_q <= '0;
                    if (!cmd_owner) last <= LW'(oh2idx(16'(grant_q)));
                end
            end
        end
    end

    assign bus.ram_rd = fwd;
    assign bus.ram_rd_done = state == RELEASE;
    assign bus.busy = state != IDLE;
    assign bus.grant = grant_q;
    assign bus.word_count = wc;
    assign bus.overrun = overrun_q;
    assign bus.timeout = timeout_q;
    assign bus.data = bus.ram_data;
endmodule
